iq_split: RTL and testbench
===========================

Name: iq_split

Overview:
- Front-end IQ deinterleaver: pops raw 8-bit bytes from one input FIFO, assembles little-endian 16-bit I and Q samples, sign-extends and quantizes them, and pushes one I word and one Q word to separate output FIFOs in the same cycle.
- It is the fan-out counterpart of the dual-FIFO combiner: one read side, two write sides with joint backpressure.
- It feeds the I and Q processing chains (FIR/demod) of the FM receiver datapath.

Parameters:
- DATA_WIDTH, 32, width of I/Q output words (must be ≥ 16 + BITS).
- BYTE_WIDTH, 8, width of the input FIFO word.
- BITS, 10, fixed-point fraction bits applied by quantization (left shift).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_dout  input  BYTE_WIDTH  input FIFO head byte (first-word-fall-through; valid when in_empty=0).
- in_empty  input  1  input FIFO empty.
- in_rd_en  output  1  pop input FIFO head this cycle.
- I_din  output  DATA_WIDTH  I sample to I FIFO.
- I_full  input  1  I FIFO full.
- I_wr_en  output  1  push I_din this cycle.
- Q_din  output  DATA_WIDTH  Q sample to Q FIFO.
- Q_full  input  1  Q FIFO full.
- Q_wr_en  output  1  push Q_din this cycle.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and sampled only on the rising edge of clock.
- Reset state: state=S_READ, byte_cnt=0, assembly regs I_lo/I_hi/Q_lo/Q_hi=0. All outputs are combinational from state. During and after reset: in_rd_en=0, I_wr_en=0, Q_wr_en=0, I_din=0, Q_din=0.
- S_READ:
  - in_rd_en = !in_empty. When asserted, the head byte is captured by byte_cnt: 0→I_lo, 1→I_hi, 2→Q_lo, 3→Q_hi; then byte_cnt increments.
  - Capture of byte 3 → byte_cnt wraps to 0 and state goes to S_WRITE.
  - in_empty=1 → no pop; byte_cnt and regs hold indefinitely.
- S_WRITE:
  - in_rd_en=0. If !I_full && !Q_full: I_wr_en=Q_wr_en=1 in the same cycle, then state goes to S_READ.
  - Otherwise hold with no writes. I and Q are never written separately, so they stay sample-aligned.
- Arithmetic:
  - I16={I_hi,I_lo}, Q16={Q_hi,Q_lo}, both two's complement.
  - Output = sign-extend to DATA_WIDTH, then shift left by BITS (arithmetic; no saturation needed given the DATA_WIDTH constraint).
  - I_din/Q_din are driven with these values only while in S_WRITE, and are 0 otherwise.
- Throughput: minimum 5 cycles per IQ pair (4 pops + 1 write). Latency from the 4th pop to the write is 1 cycle when the outputs are not full.
- Simultaneous events: reset wins over any pop/write. A partial frame (byte_cnt 1–3) is discarded on reset, and a pending S_WRITE pair is dropped.
- No X on outputs in any state. Illegal state encodings recover to S_READ with byte_cnt=0.

Optional Feature:
- Macro IQ_QUANT_EN.
- Defined: outputs are sign-extended and shifted left by BITS as above.
- Undefined: outputs are sign-extended raw 16-bit values (no shift); BITS is unused. All timing and handshakes are identical.

Test Plan:
- Basic, IQ_QUANT_EN defined: bytes 0x34,0x12,0x78,0x56 with FIFOs never full → single joint write I_din=0x0048D000, Q_din=0x0159E000; exactly 4 in_rd_en pulses, then 1 write cycle.
- Negative values: bytes 0x00,0x80,0xFF,0xFF → I_din=0xFE000000, Q_din=0xFFFFFC00. With IQ_QUANT_EN undefined, same bytes → I_din=0xFFFF8000, Q_din=0xFFFFFFFF.
- Input gaps: in_empty toggles every other cycle across 8 bytes (two frames) → two correct pairs; no pop while in_empty=1; byte order preserved.
- Backpressure: Q_full=1 for 10 cycles at entry to S_WRITE, I_full=0 → I_wr_en and Q_wr_en stay 0 and in_rd_en stays 0; one joint write in the cycle Q_full drops.
- Reset mid-frame: pop 0xAA,0xBB, assert reset 1 cycle, then feed 0x01,0x00,0x02,0x00 → I_din=0x00000400, Q_din=0x00000800 (quantized); no stale bytes used; outputs 0 during reset.
- Streaming: 256 random frames with random I_full/Q_full/in_empty → output sequences match the reference model in order; I and Q write counts always equal.

Source files
------------

// File: rtl/iq_split_if.sv
// Byte-in / dual-word-out FIFO handshake bundle for the IQ deinterleaver.
// master = deinterleaver side, slave = the FIFOs around it.
interface iq_split_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] I_din;
  logic                  I_full;
  logic                  I_wr_en;
  logic [DATA_WIDTH-1:0] Q_din;
  logic                  Q_full;
  logic                  Q_wr_en;

  modport master (
    input  in_dout, in_empty, I_full, Q_full,
    output in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
  );

  modport slave (
    output in_dout, in_empty, I_full, Q_full,
    input  in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
  );
endinterface

// File: rtl/iq_split.sv
// IQ deinterleaver: 4 pops (I_lo,I_hi,Q_lo,Q_hi) then one joint I/Q write 1 cycle later; stalls while either output is full.
// IQ_QUANT_EN defined: outputs shifted left by BITS; undefined: sign-extended raw samples.
module iq_split #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int BITS       = 10
) (
  input  logic       clock,
  input  logic       reset,
  iq_split_if.master bus
);

  localparam int SAMPLE_W = 2 * BYTE_WIDTH;
`ifdef IQ_QUANT_EN
  localparam int SHIFT = BITS;
`else
  localparam int SHIFT = 0;
`endif

  if (DATA_WIDTH < SAMPLE_W + BITS) begin : g_bad_cfg
    $error("iq_split: DATA_WIDTH too narrow for sample plus BITS");
  end

  typedef enum logic [1:0] {
    S_READ  = 2'b01,
    S_WRITE = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [BYTE_WIDTH-1:0] i_lo_q, i_lo_d, i_hi_q, i_hi_d;
  logic [BYTE_WIDTH-1:0] q_lo_q, q_lo_d, q_hi_q, q_hi_d;

  logic                  rd_en, wr_en;
  logic [DATA_WIDTH-1:0] i_out, q_out;
  logic [SAMPLE_W-1:0]   i16, q16;
  logic [DATA_WIDTH-1:0] i_ext, q_ext;

  assign i16   = {i_hi_q, i_lo_q};
  assign q16   = {q_hi_q, q_lo_q};
  assign i_ext = {{(DATA_WIDTH-SAMPLE_W){i16[SAMPLE_W-1]}}, i16};
  assign q_ext = {{(DATA_WIDTH-SAMPLE_W){q16[SAMPLE_W-1]}}, q16};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    i_lo_d     = i_lo_q;
    i_hi_d     = i_hi_q;
    q_lo_d     = q_lo_q;
    q_hi_d     = q_hi_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    i_out      = '0;
    q_out      = '0;

    case (state_q)
      S_READ: begin
        rd_en = !bus.in_empty;
        if (rd_en) begin
          case (byte_cnt_q)
            2'd0:    i_lo_d = bus.in_dout;
            2'd1:    i_hi_d = bus.in_dout;
            2'd2:    q_lo_d = bus.in_dout;
            default: q_hi_d = bus.in_dout;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Both words go out together or not at all so I/Q never drift apart.
        i_out = i_ext << SHIFT;
        q_out = q_ext << SHIFT;
        if (!bus.I_full && !bus.Q_full) begin
          wr_en   = 1'b1;
          state_d = S_READ;
        end
      end
      default: begin
        state_d    = S_READ;
        byte_cnt_d = 2'd0;
      end
    endcase

    // A synchronous reset still masks this cycle's pop/write.
    if (reset) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
      i_out = '0;
      q_out = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_READ;
      byte_cnt_q <= 2'd0;
      i_lo_q     <= '0;
      i_hi_q     <= '0;
      q_lo_q     <= '0;
      q_hi_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      i_lo_q     <= i_lo_d;
      i_hi_q     <= i_hi_d;
      q_lo_q     <= q_lo_d;
      q_hi_q     <= q_hi_d;
    end
  end

  assign bus.in_rd_en = rd_en;
  assign bus.I_wr_en  = wr_en;
  assign bus.Q_wr_en  = wr_en;
  assign bus.I_din    = i_out;
  assign bus.Q_din    = q_out;

endmodule

// File: tb/tb_iq_split.sv
// Bench for iq_split: byte-stream FIFO model in, expected I/Q pair queue out, per-cycle handshake checks.
module tb_iq_split;
  localparam int DW   = 32;
  localparam int BW   = 8;
  localparam int BITS = 10;
`ifdef IQ_QUANT_EN
  localparam int SHIFT = BITS;
`else
  localparam int SHIFT = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  iq_split_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus_if ();

  iq_split #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .BITS(BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } pair_t;

  logic [BW-1:0] src[$];
  pair_t         exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int pops     = 0;   // bytes of the current frame already consumed; 4 = pair waiting to be written
  int cyc      = 0;
  int p_empty  = 0;
  int p_ifull  = 0;
  int p_qfull  = 0;
  int n_iw     = 0;
  int n_qw     = 0;
  int n_frames = 0;
  bit toggle   = 1'b0;
  bit rst_req  = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [7:0] lo, input logic [7:0] hi);
    logic [DW-1:0] v;
    v = {{(DW-16){hi[7]}}, hi, lo};
    return v << SHIFT;
  endfunction

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1);
    src.push_back(b0);
    src.push_back(b1);
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    pair_t p;
    push_bytes(b0, b1);
    push_bytes(b2, b3);
    p.i = model(b0, b1);
    p.q = model(b2, b3);
    exp_q.push_back(p);
    n_frames++;
  endtask

  task automatic step();
    bit empty, ifull, qfull, live, exp_rd, exp_wr;
    logic [DW-1:0] exp_i, exp_q_v;
    @(negedge clock);
    cyc++;
    if (src.size() == 0)  empty = 1'b1;
    else if (toggle)      empty = cyc[0];
    else                  empty = ($urandom_range(99) < p_empty);
    ifull = ($urandom_range(99) < p_ifull);
    qfull = ($urandom_range(99) < p_qfull);
    bus_if.in_empty = empty;
    bus_if.in_dout  = empty ? 8'($urandom) : src[0];
    bus_if.I_full   = ifull;
    bus_if.Q_full   = qfull;
    reset           = rst_req;
    #1;
    live    = !rst_req;
    exp_rd  = live && (pops < 4) && !empty;
    exp_wr  = live && (pops == 4) && !ifull && !qfull;
    exp_i   = '0;
    exp_q_v = '0;
    if (live && pops == 4 && exp_q.size() > 0) begin
      exp_i   = exp_q[0].i;
      exp_q_v = exp_q[0].q;
    end
    check("in_rd_en", 64'(bus_if.in_rd_en), 64'(exp_rd));
    check("I_wr_en",  64'(bus_if.I_wr_en),  64'(exp_wr));
    check("Q_wr_en",  64'(bus_if.Q_wr_en),  64'(exp_wr));
    check("I_din",    64'(bus_if.I_din),    64'(exp_i));
    check("Q_din",    64'(bus_if.Q_din),    64'(exp_q_v));
    if (bus_if.I_wr_en) n_iw++;
    if (bus_if.Q_wr_en) n_qw++;
    if (rst_req) begin
      if (pops == 4) begin
        void'(exp_q.pop_front());
        n_frames--;
      end
      pops = 0;
    end else if (exp_rd) begin
      void'(src.pop_front());
      pops++;
    end else if (exp_wr) begin
      void'(exp_q.pop_front());
      pops = 0;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() > 0 || pops > 0) && k < budget) begin
      step();
      k++;
    end
    if (exp_q.size() > 0 || pops > 0) check("drain_timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pops != n && k < budget) begin
      step();
      k++;
    end
    if (pops != n) check("wait_pops_timeout", 64'(pops), 64'(n));
  endtask

  initial begin
    bus_if.in_dout  = '0;
    bus_if.in_empty = 1'b1;
    bus_if.I_full   = 1'b0;
    bus_if.Q_full   = 1'b0;

    // Reset with a frame already waiting: nothing may be popped or written.
    push_frame(8'h34, 8'h12, 8'h78, 8'h56);
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    drain(50);

    push_frame(8'h00, 8'h80, 8'hFF, 8'hFF);
    drain(50);

    // Input gaps on alternate cycles over two frames.
    toggle = 1'b1;
    push_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    push_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    drain(100);
    toggle = 1'b0;

    // Q side full for 10 cycles once a pair is ready; next frame bytes are available.
    push_frame(8'h11, 8'h22, 8'h33, 8'h44);
    push_frame(8'h55, 8'h66, 8'h77, 8'h88);
    p_qfull = 100;
    wait_pops(4, 20);
    repeat (10) step();
    p_qfull = 0;
    drain(100);

    // Reset mid-frame: the two partial bytes must not leak into the next pair.
    push_bytes(8'hAA, 8'hBB);
    wait_pops(2, 20);
    push_frame(8'h01, 8'h00, 8'h02, 8'h00);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    drain(50);

    // Randomized streaming with random gaps and backpressure.
    p_empty = 30;
    p_ifull = 30;
    p_qfull = 30;
    for (int f = 0; f < 256; f++)
      push_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    drain(20000);
    p_empty = 0;
    p_ifull = 0;
    p_qfull = 0;
    repeat (3) step();

    check("iq_write_counts_equal", 64'(n_iw), 64'(n_qw));
    check("total_writes", 64'(n_iw), 64'(n_frames));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
